// File: rtl/cpu_pkg.sv
// Shared RISC-V opcode constants, sequencer state type and opcode classifiers.
// Used by cpu_phase_sequencer and control_unit.
package cpu_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_L    = 7'b0000011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } seq_state_t;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_S, OP_L, OP_B, OP_JAL, OP_JALR: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic writes_rd(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_L, OP_JAL, OP_JALR: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_L) || (op == OP_S);
    endfunction

endpackage

// File: rtl/cpu_phase_sequencer_if.sv
// Sequencer <-> datapath bundle. master = sequencer, slave = datapath/RAM side.
// mem_tmo exists only when SEQ_MEM_TIMEOUT_EN is defined.
interface cpu_phase_sequencer_if #(
    parameter int PC_W  = 11,
    parameter int CNT_W = 32
);
    logic             run;
    logic             step;
    logic [6:0]       opcode;
    logic [PC_W-1:0]  pc_next;
    logic             mem_ack;
    logic [PC_W-1:0]  pc;
    logic             rom_en;
    logic             ram_req;
    logic             rf_we;
    logic             pc_we;
    logic             busy;
    logic             halted;
    logic             bad_op;
    logic [CNT_W-1:0] instret;
`ifdef SEQ_MEM_TIMEOUT_EN
    logic             mem_tmo;
`endif

    modport master (
        input  run, step, opcode, pc_next, mem_ack,
        output pc, rom_en, ram_req, rf_we, pc_we, busy, halted, bad_op, instret
`ifdef SEQ_MEM_TIMEOUT_EN
        , output mem_tmo
`endif
    );

    modport slave (
        output run, step, opcode, pc_next, mem_ack,
        input  pc, rom_en, ram_req, rf_we, pc_we, busy, halted, bad_op, instret
`ifdef SEQ_MEM_TIMEOUT_EN
        , input mem_tmo
`endif
    );

endinterface

// File: rtl/cpu_phase_sequencer_seq_pc_reg.sv
// Program counter and retired-instruction counter; both advance on the WB load strobe.
module seq_pc_reg #(
    parameter int PC_W     = 11,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld,
    input  logic [PC_W-1:0]  pc_next,
    output logic [PC_W-1:0]  pc,
    output logic [CNT_W-1:0] instret
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= PC_W'(RESET_PC);
            instret <= '0;
        end else if (ld) begin
            pc      <= pc_next;
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle phase sequencer: one clock plus per-phase strobes for ROM, RAM, regfile and PC.
// Optional RAM wait timeout enabled by defining SEQ_MEM_TIMEOUT_EN.
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W     = 11,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
`ifdef SEQ_MEM_TIMEOUT_EN
    , parameter int MEM_TMO = 15
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    cpu_phase_sequencer_if.master bus
);

    seq_state_t state, state_nx;
    logic       step_mode;
    logic [6:0] op_q;
    logic       bad_op_q;
    logic       op_legal;

    logic rom_en_c, ram_req_c, rf_we_c, pc_we_c, busy_c, halted_c;

    assign op_legal = is_legal_op(bus.opcode);

`ifdef SEQ_MEM_TIMEOUT_EN
    localparam int TMO_W = ($clog2(MEM_TMO + 1) > 4) ? $clog2(MEM_TMO + 1) : 4;
    logic [TMO_W-1:0] wait_cnt;
    logic             tmo_q;
    logic             tmo_hit;

    // wait_cnt holds the number of un-acked MEM cycles already spent
    assign tmo_hit = (state == ST_MEM) && !bus.mem_ack &&
                     (wait_cnt == TMO_W'(MEM_TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            if (state == ST_MEM && !bus.mem_ack) wait_cnt <= wait_cnt + TMO_W'(1);
            else                                 wait_cnt <= '0;
            if (tmo_hit) tmo_q <= 1'b1;
        end
    end

    assign bus.mem_tmo = tmo_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_mode <= 1'b0;
            op_q      <= OP_R;
            bad_op_q  <= 1'b0;
        end else begin
            if (state == ST_IDLE && (bus.run || bus.step)) step_mode <= ~bus.run;
            if (state == ST_DECODE) begin
                if (op_legal) op_q     <= bus.opcode;
                else          bad_op_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (bus.run || bus.step) state_nx = ST_FETCH;
            ST_FETCH:  state_nx = ST_DECODE;
            ST_DECODE: state_nx = op_legal ? ST_EXEC : ST_HALT;
            ST_EXEC:   state_nx = is_mem_op(op_q) ? ST_MEM : ST_WB;
            ST_MEM: begin
                if (bus.mem_ack) state_nx = ST_WB;
`ifdef SEQ_MEM_TIMEOUT_EN
                else if (tmo_hit) state_nx = ST_HALT;
`endif
            end
            // step_mode forces a return to IDLE even if run was raised mid-instruction
            ST_WB:     state_nx = (step_mode || !bus.run) ? ST_IDLE : ST_FETCH;
            ST_HALT:   state_nx = ST_HALT;
            default:   state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        rom_en_c  = (state == ST_FETCH);
        ram_req_c = (state == ST_MEM);
        rf_we_c   = (state == ST_WB) && writes_rd(op_q);
        pc_we_c   = (state == ST_WB);
        busy_c    = (state != ST_IDLE) && (state != ST_HALT);
        halted_c  = (state == ST_HALT);
    end

    assign bus.rom_en  = rom_en_c;
    assign bus.ram_req = ram_req_c;
    assign bus.rf_we   = rf_we_c;
    assign bus.pc_we   = pc_we_c;
    assign bus.busy    = busy_c;
    assign bus.halted  = halted_c;
    assign bus.bad_op  = bad_op_q;

    seq_pc_reg #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC),
        .CNT_W    (CNT_W)
    ) u_pc_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .ld      (pc_we_c),
        .pc_next (bus.pc_next),
        .pc      (bus.pc),
        .instret (bus.instret)
    );

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed + randomized bench for cpu_phase_sequencer with an instruction-level timing model.
module tb_cpu_phase_sequencer;

    localparam int PC_W  = 11;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    cpu_phase_sequencer_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    cpu_phase_sequencer #(.PC_W(PC_W), .RESET_PC(0), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction classes: index 0..6 = R, I, S, L, B, JAL, JALR
    logic [6:0] ops [7] = '{7'b0110011, 7'b0010011, 7'b0100011, 7'b0000011,
                            7'b1100011, 7'b1101111, 7'b1100111};
    bit         wrd [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    bit         mem [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    int vectors     = 0;
    int miscompares = 0;

    logic [PC_W-1:0]  m_pc;
    logic [CNT_W-1:0] m_ret;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {bus.rom_en, bus.ram_req, bus.rf_we, bus.pc_we, bus.busy, bus.halted, bus.bad_op};
    endfunction

    // Runs one legal instruction from its FETCH to its WB and checks the per-instruction profile.
    task automatic exec_instr(input int k, input logic [PC_W-1:0] pn, input int dly,
                              input bit poke_step, input bit drop_run);
        int waitc = 0, cyc = 0, reqc = 0, rfc = 0, pcc = 0, romc = 0, nbusy = 0;
        bit multi = 1'b0, done = 1'b0;
        bus.opcode  = ops[k];
        bus.pc_next = pn;
        bus.mem_ack = 1'b0;
        do begin
            @(negedge clk);
            bus.step = 1'b0;
            waitc++;
        end while (!bus.rom_en && waitc < 20);
        chk("fetch_wait", 64'(waitc), 64'd1);
        while (!done && cyc < 40) begin
            cyc++;
            romc  += int'(bus.rom_en);
            reqc  += int'(bus.ram_req);
            rfc   += int'(bus.rf_we);
            pcc   += int'(bus.pc_we);
            nbusy += int'(!bus.busy);
            if (int'(bus.rom_en) + int'(bus.ram_req) + int'(bus.rf_we) > 1) multi = 1'b1;
            // ack outside MEM is noise the sequencer must ignore
            if (bus.ram_req) bus.mem_ack = (reqc == dly + 1);
            else             bus.mem_ack = 1'($urandom_range(0, 1));
            bus.step = poke_step && (cyc == 2);
            if (drop_run && cyc == 3) bus.run = 1'b0;
            if (bus.pc_we) done = 1'b1;
            else           @(negedge clk);
        end
        chk("cpi",        64'(cyc),  64'(mem[k] ? 5 + dly : 4));
        chk("rom_en_cnt", 64'(romc), 64'd1);
        chk("ram_req_cnt",64'(reqc), 64'(mem[k] ? dly + 1 : 0));
        chk("rf_we_cnt",  64'(rfc),  64'(wrd[k]));
        chk("pc_we_cnt",  64'(pcc),  64'd1);
        chk("one_hot",    64'(multi),64'd0);
        chk("busy_low",   64'(nbusy),64'd0);
        m_pc  = pn;
        m_ret = m_ret + 1;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        bus.step    = 1'b0;
        chk("pc",      64'(bus.pc),      64'(m_pc));
        chk("instret", 64'(bus.instret), 64'(m_ret));
    endtask

    initial begin
        int k, dly, romc, reqc, pulses, waitc;
        logic [PC_W-1:0] pn;

        rst_n = 1'b0;
        bus.run = 1'b0; bus.step = 1'b0; bus.opcode = 7'd0;
        bus.pc_next = '0; bus.mem_ack = 1'b0;
        m_pc = '0; m_ret = '0;
        repeat (2) @(negedge clk);
        chk("reset_strobes", 64'(strobes()), 64'd0);
        chk("reset_pc",      64'(bus.pc),    64'd0);
        chk("reset_instret", 64'(bus.instret), 64'd0);

        // free-run: R-type, load with 3 wait cycles, store, branch to 0x7FC, wrap to 0
        rst_n   = 1'b1;
        bus.run = 1'b1;
        exec_instr(0, 11'd4, 0, 1'b0, 1'b0);
        exec_instr(3, 11'd8, 3, 1'b0, 1'b0);
        exec_instr(2, 11'd12, 1, 1'b0, 1'b0);
        exec_instr(4, 11'h7FC, 0, 1'b0, 1'b0);
        pn = PC_W'(12'h7FC + 12'd4);
        exec_instr(0, pn, 0, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) begin
            k   = int'($urandom_range(0, 6));
            dly = int'($urandom_range(0, 4));
            pn  = PC_W'($urandom);
            exec_instr(k, pn, dly, 1'b0, 1'b0);
        end

        // run dropped mid-instruction: finishes, then idles
        exec_instr(1, 11'h040, 0, 1'b0, 1'b1);
        romc = 0;
        repeat (4) begin @(negedge clk); romc += int'(bus.rom_en) + int'(bus.busy); end
        chk("idle_after_run_drop", 64'(romc), 64'd0);

        // single step with a second step poked while busy
        bus.step = 1'b1;
        exec_instr(3, 11'h100, 2, 1'b1, 1'b0);
        romc = 0;
        repeat (5) begin @(negedge clk); romc += int'(bus.rom_en) + int'(bus.busy); end
        chk("idle_after_step", 64'(romc), 64'd0);
        chk("instret_after_step", 64'(bus.instret), 64'(m_ret));

        // illegal opcode halts without touching pc/instret
        bus.opcode = 7'b0000000;
        bus.run    = 1'b1;
        waitc = 0;
        do begin @(negedge clk); waitc++; end while (!bus.rom_en && waitc < 20);
        chk("illegal_fetch_wait", 64'(waitc), 64'd1);
        repeat (2) @(negedge clk);
        chk("halt_strobes", 64'(strobes()), 64'b0000011);
        chk("halt_pc",      64'(bus.pc),    64'(m_pc));
        chk("halt_instret", 64'(bus.instret), 64'(m_ret));
        romc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.step = i[0];
            bus.opcode = ops[i % 7];
            @(negedge clk);
            romc += int'(bus.rom_en) + int'(bus.rf_we) + int'(bus.pc_we) + int'(bus.busy);
        end
        bus.step = 1'b0;
        chk("halt_absorbing", 64'(romc), 64'd0);
        chk("halt_sticky",    64'(strobes()), 64'b0000011);
        rst_n = 1'b0;
        #1;
        chk("reset_clears_halt", 64'(strobes()), 64'd0);
        m_pc = '0; m_ret = '0;

        // async reset while stalled in MEM
        @(negedge clk);
        rst_n = 1'b1;
        exec_instr(0, 11'h123, 0, 1'b0, 1'b0);
        bus.opcode  = ops[3];
        bus.mem_ack = 1'b0;
        waitc = 0;
        do begin @(negedge clk); waitc++; end while (!bus.ram_req && waitc < 20);
        chk("reached_mem", 64'(bus.ram_req), 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mem_reset_strobes", 64'(strobes()), 64'd0);
        chk("mem_reset_pc",      64'(bus.pc),    64'd0);
        chk("mem_reset_instret", 64'(bus.instret), 64'd0);
        @(posedge clk);
        #1;
        chk("mem_reset_hold", 64'(strobes()), 64'd0);

`ifdef SEQ_MEM_TIMEOUT_EN
        // MEM with no ack times out after 15 wait cycles
        @(negedge clk);
        rst_n = 1'b1;
        bus.run = 1'b1;
        bus.opcode = ops[3];
        reqc = 0;
        pulses = 0;
        while (!bus.halted && pulses < 60) begin
            @(negedge clk);
            pulses++;
            reqc += int'(bus.ram_req);
        end
        chk("tmo_req_cycles", 64'(reqc), 64'd15);
        chk("tmo_flag",       64'(bus.mem_tmo), 64'd1);
        chk("tmo_strobes",    64'(strobes()), 64'b0000010);
        chk("tmo_instret",    64'(bus.instret), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
